// File: rtl/pwm_ramp_sched.sv
// Steps each channel's duty cycle toward its target once per prescaled tick; channel k lands 2+k cycles after the tick.
// No backpressure: one tick may queue behind a running sweep, further ticks are dropped and flagged on overrun_o.
module pwm_ramp_sched #(
  parameter int NOutputs = 6,
  parameter int DcDw     = 16,
  parameter int PrescDw  = 8
) (
  input  logic                     clk_core_i,
  input  logic                     rst_core_i,
  input  logic                     cycle_end_i,
  input  logic [PrescDw-1:0]       presc_i,
  input  logic [NOutputs-1:0]      ramp_en_i,
  input  logic [NOutputs*DcDw-1:0] target_i,
  input  logic [NOutputs*DcDw-1:0] step_i,
  input  logic [NOutputs-1:0]      set_i,
  input  logic [DcDw-1:0]          set_val_i,
  output logic [NOutputs*DcDw-1:0] duty_cycle_o,
  output logic [NOutputs-1:0]      dc_update_o,
  output logic [NOutputs-1:0]      done_o,
  output logic                     busy_o,
  output logic                     overrun_o
);

  localparam int IdxW = (NOutputs > 1) ? $clog2(NOutputs) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NOutputs - 1);

  typedef enum logic {IDLE, SWEEP} state_e;

  state_e                       state_q, state_d;
  logic [IdxW-1:0]              idx_q, idx_d;
  logic                         pending_q, pending_d;
  logic                         overrun_d;
  logic [PrescDw-1:0]           cnt_q, cnt_d;
  logic                         tick;
  logic [NOutputs-1:0][DcDw-1:0] dc_q, dc_d;
  logic [NOutputs-1:0]          upd_q, upd_d;
  logic [DcDw-1:0]              cur, tgt, stp, diff, stepped;
  logic                         en_sel;

  assign tick = cycle_end_i && (cnt_q == presc_i);

  always_comb begin
    cnt_d = cnt_q;
    if (cycle_end_i) cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    overrun_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick || pending_q) begin
          state_d   = SWEEP;
          idx_d     = '0;
          pending_d = 1'b0;
          overrun_d = tick && pending_q;
        end
      end
      SWEEP: begin
        if (idx_q == LastIdx) state_d = IDLE;
        else                  idx_d   = idx_q + 1'b1;
        // Only one tick can wait behind the running sweep
        if (tick) begin
          if (pending_q) overrun_d = 1'b1;
          else           pending_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cur    = '0;
    tgt    = '0;
    stp    = '0;
    en_sel = 1'b0;
    for (int k = 0; k < NOutputs; k++) begin
      if (idx_q == IdxW'(k)) begin
        cur    = dc_q[k];
        tgt    = target_i[k*DcDw +: DcDw];
        stp    = step_i[k*DcDw +: DcDw];
        en_sel = ramp_en_i[k];
      end
    end
  end

  // Distance is always taken as the non-negative difference, so the step clamps at target
  always_comb begin
    diff    = (cur < tgt) ? (tgt - cur) : (cur - tgt);
    stepped = cur;
    if (cur != tgt) begin
      if (diff <= stp)     stepped = tgt;
      else if (cur < tgt)  stepped = cur + stp;
      else                 stepped = cur - stp;
    end
  end

  always_comb begin
    dc_d  = dc_q;
    upd_d = '0;
    for (int k = 0; k < NOutputs; k++) begin
      if (set_i[k])
        dc_d[k] = set_val_i;
      else if ((state_q == SWEEP) && en_sel && (idx_q == IdxW'(k)))
        dc_d[k] = stepped;
      upd_d[k] = (dc_d[k] != dc_q[k]);
    end
  end

  always_ff @(posedge clk_core_i) begin
    if (rst_core_i) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      pending_q <= 1'b0;
      overrun_o <= 1'b0;
      cnt_q     <= '0;
      dc_q      <= '0;
      upd_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      overrun_o <= overrun_d;
      cnt_q     <= cnt_d;
      dc_q      <= dc_d;
      upd_q     <= upd_d;
    end
  end

  assign duty_cycle_o = dc_q;
  assign dc_update_o  = upd_q;
  assign busy_o       = (state_q == SWEEP);

  always_comb begin
    done_o = '0;
    for (int k = 0; k < NOutputs; k++) done_o[k] = (dc_q[k] == target_i[k*DcDw +: DcDw]);
  end

endmodule
